mr_rf_scoreboard: RTL and testbench
===================================

Name: mr_rf_scoreboard

Overview:
- Parametrised register file plus per-register pending-write scoreboard for the decode stage.
- Generalises the single-read-pair, single-writeback, 2-bit-counter scheme to:
  - NRD read ports,
  - NWB writeback ports,
  - configurable counter width,
  - claim back-pressure on counter saturation,
  - a sticky error flag.
- Sits between decode (read/claim side) and writeback (retire side); decode instantiates one and derives its stall from the hazard outputs.

Parameters:
XLEN, 32, data width
NREGS, 32, architectural registers; reg 0 hardwired zero
NRD, 2, read ports
NWB, 1, writeback ports
CNT_BITS, 2, pending-write counter width per register
RSEL, $clog2(NREGS), register select width (derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  reset
rd_sel  in  NRD*RSEL  read register selects, port i at [i*RSEL +: RSEL]
rd_use  in  NRD  read port i is actually used by the current instruction
rd_data  out  NRD*XLEN  read data
rd_hazard  out  NRD  port i used, reg nonzero, pending count nonzero
claim_valid  in  1  decode dispatching an instruction that writes claim_reg
claim_reg  in  RSEL  destination register
claim_ready  out  1  claim can be accepted this cycle
wb_valid  in  NWB  writeback port valid
wb_reg  in  NWB*RSEL  writeback destinations
wb_val  in  NWB*XLEN  writeback data
flush  in  1  pipeline flush
pending_any  out  1  some register has nonzero count
sb_err  out  1  sticky scoreboard error

Behaviour:
- Reset: rst is synchronous, active-high, on clk.
  - All regfile entries and counters clear to 0.
  - sb_err clears to 0.
  - claim_ready is 0 while rst is high.
  - rd_data reads 0, rd_hazard reads 0, pending_any reads 0.
- Reads are combinational from current state.
  - rd_sel==0 gives data 0 and never a hazard.
  - Writes become visible the cycle after wb_valid.
- claim_ready = !rst & (claim_reg==0 | cnt[claim_reg] != max).
  - max = 2^CNT_BITS-1.
  - Claim accepted = claim_valid & claim_ready & !flush.
  - claim_reg==0 is accepted and has no effect.
- Per cycle, counter next value: cnt + accepted_claim_match - (number of valid WB ports with matching nonzero wb_reg).
  - Claim and retire to the same register in the same cycle net out.
  - Arithmetic is done at CNT_BITS+$clog2(NWB+1)+1 bits.
  - A result below 0 clamps to 0 and sets sb_err (WB without claim).
  - A result above max clamps to max and sets sb_err; this is unreachable when claim_ready is honoured.
- WB data:
  - Writes to reg 0 are ignored.
  - If several WB ports hit the same register in one cycle, the highest-index port's data wins, and sb_err is set.
- flush:
  - All counters clear to 0 next cycle; any claim in that cycle is dropped.
  - WB data writes in the flush cycle still update the regfile; their decrements are discarded.
  - sb_err is not cleared by flush.
- pending_any: combinational OR over all counters.
- Reset mid-operation: a same-cycle claim, WB or flush is discarded; state reads as reset state the next cycle.
- Latency: claim and WB effects on rd_hazard, rd_data and claim_ready appear 1 cycle later (without the bypass below).
- Non-synthesis builds assert !sb_err rising.

Optional Feature:
- Macro: MR_RF_WB_BYPASS_EN.
- Defined:
  - rd_data forwards same-cycle WB data; the highest-index matching valid WB port wins.
  - rd_hazard on port i is suppressed when cnt[rd_sel]==1 and a valid WB port retires that register this cycle, with no same-cycle accepted claim to it.
  - claim_ready likewise treats a same-cycle retire as freeing one slot.
  - Gives 0-cycle WB-to-decode latency.
- Undefined: pure registered behaviour as above; the combinational path wb_* -> rd_* / claim_ready does not exist.

Test Plan:
- Reset, then read x5 and x0 -> rd_data 0, rd_hazard 0, pending_any 0, claim_ready 1.
- Claim x5; next cycle rd_sel=5, rd_use=1 -> rd_hazard 1; WB x5=0xDEADBEEF -> next cycle hazard 0, data 0xDEADBEEF.
- CNT_BITS=2: claim x7 three times -> claim_ready 0 for x7 and 1 for x8; retire one -> claim_ready for x7 returns 1 next cycle.
- Same-cycle claim x3 and WB x3 with cnt=1 -> count stays 1, hazard stays 1, data updated.
- NWB=2: both ports WB x9 (0x1, 0x2) with cnt=2 -> cnt 0, data 0x2, sb_err 1 (duplicate-port rule). Then WB x4 with cnt=0 -> sb_err stays 1, cnt stays 0.
- Claim x1, x2, then flush with simultaneous claim x6 and WB x1=0x55 -> next cycle pending_any 0, x1 reads 0x55, x6 not pending. With MR_RF_WB_BYPASS_EN: WB x5=0x12 with cnt=1 -> same-cycle rd_data 0x12, rd_hazard 0.

Source files
------------

// File: rtl/mr_rf_scoreboard.sv
// mr_rf_scoreboard
//   Register file plus per-register pending-write scoreboard for the decode
//   stage. Decode reads operands through NRD read ports and claims a
//   destination register when it dispatches a writer. Writeback retires
//   claims through NWB ports and writes the register file. Each register has
//   a CNT_BITS-wide count of outstanding writers. rd_hazard flags reads of a
//   register that still has writers in flight.
//
//   Optional build macro: MR_RF_WB_BYPASS_EN
//     When defined, same-cycle writeback data is forwarded to the read ports.
//     A same-cycle retire can also clear a hazard or free a claim slot.
//     When undefined, all outputs come only from registered state.
//
//   Ports
//     clk, rst        clock, synchronous active-high reset
//     rd_sel_i        NRD read selects, port i at [i*RSEL +: RSEL]
//     rd_use_i        per-port "operand actually used"
//     rd_data_o       NRD read data, port i at [i*XLEN +: XLEN]
//     rd_hazard_o     per-port: used, nonzero register, writes pending
//     claim_valid_i   decode dispatches a writer of claim_reg_i
//     claim_reg_i     destination register of that writer
//     claim_ready_o   a claim to claim_reg_i can be accepted this cycle
//     wb_valid_i      per writeback port valid
//     wb_reg_i        writeback destinations, port p at [p*RSEL +: RSEL]
//     wb_val_i        writeback data, port p at [p*XLEN +: XLEN]
//     flush_i         drop all pending counts (regfile writes still land)
//     pending_any_o   some register has a nonzero pending count
//     sb_err_o        sticky error: retire without claim, counter overflow,
//                     or several writeback ports hitting one register
//
//   CHECK_SB_ERR enables the simulation-only assertion that sb_err_o never
//   rises. Benches that provoke errors on purpose set it to 0.
module mr_rf_scoreboard #(
  parameter int XLEN         = 32,
  parameter int NREGS        = 32,
  parameter int NRD          = 2,
  parameter int NWB          = 1,
  parameter int CNT_BITS     = 2,
  parameter bit CHECK_SB_ERR = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NRD*$clog2(NREGS)-1:0]   rd_sel_i,
  input  logic [NRD-1:0]                 rd_use_i,
  output logic [NRD*XLEN-1:0]            rd_data_o,
  output logic [NRD-1:0]                 rd_hazard_o,
  input  logic                           claim_valid_i,
  input  logic [$clog2(NREGS)-1:0]       claim_reg_i,
  output logic                           claim_ready_o,
  input  logic [NWB-1:0]                 wb_valid_i,
  input  logic [NWB*$clog2(NREGS)-1:0]   wb_reg_i,
  input  logic [NWB*XLEN-1:0]            wb_val_i,
  input  logic                           flush_i,
  output logic                           pending_any_o,
  output logic                           sb_err_o
);

  localparam int RSEL = $clog2(NREGS);
  // The extra bits let a claim and NWB retires be combined without
  // wrapping. The MSB is the sign of the result.
  localparam int AW   = CNT_BITS + $clog2(NWB + 1) + 1;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]     regs_q [NREGS];
  logic [XLEN-1:0]     regs_d [NREGS];
  logic [CNT_BITS-1:0] cnt_q  [NREGS];
  logic [CNT_BITS-1:0] cnt_d  [NREGS];
  logic                sb_err_q, sb_err_d;

  logic [AW-1:0]       ret_cnt [NREGS];  // valid WB ports retiring each reg
  logic [AW-1:0]       cnt_sum;
  logic                cnt_err, dup_err;
  logic                claim_free, claim_acc;
  logic [RSEL-1:0]     rd_sel_w [NRD];

  // Number of valid writeback ports targeting each nonzero register.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      ret_cnt[r] = '0;
      for (int p = 0; p < NWB; p++) begin
        if (r != 0 && wb_valid_i[p] && wb_reg_i[p*RSEL +: RSEL] == RSEL'(r))
          ret_cnt[r] = ret_cnt[r] + AW'(1);
      end
    end
  end

  // claim_ready does not depend on claim_valid_i, so there is no loop here.
  always_comb begin
    claim_free = (cnt_q[claim_reg_i] != CNT_MAX);
`ifdef MR_RF_WB_BYPASS_EN
    claim_free = claim_free || (ret_cnt[claim_reg_i] != '0);
`endif
  end

  assign claim_ready_o = !rst && (claim_reg_i == '0 || claim_free);
  assign claim_acc     = claim_valid_i && claim_ready_o && !flush_i;

  // Regfile next state. Ascending port order lets the highest index win.
  always_comb begin
    // NOTE: defaulting every combinational output first avoids inferring latches.
    dup_err = 1'b0;
    for (int r = 0; r < NREGS; r++) regs_d[r] = regs_q[r];
    for (int p = 0; p < NWB; p++) begin
      if (wb_valid_i[p] && wb_reg_i[p*RSEL +: RSEL] != '0)
        regs_d[wb_reg_i[p*RSEL +: RSEL]] = wb_val_i[p*XLEN +: XLEN];
    end
    for (int r = 0; r < NREGS; r++) begin
      if (ret_cnt[r] > AW'(1)) dup_err = 1'b1;
    end
  end

  // Pending counters. A flush clears them all and drops this cycle's claim
  // and retire accounting, including any underflow error.
  always_comb begin
    cnt_err = 1'b0;
    cnt_sum = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = '0;
      cnt_sum  = AW'(cnt_q[r]) + AW'(claim_acc && claim_reg_i == RSEL'(r))
                 - ret_cnt[r];
      if (r != 0 && !flush_i) begin
        if (cnt_sum[AW-1]) begin
          cnt_err = 1'b1;                  // retire without a claim
        end else if (cnt_sum > AW'(CNT_MAX)) begin
          cnt_d[r] = CNT_MAX;
          cnt_err  = 1'b1;
        end else begin
          cnt_d[r] = cnt_sum[CNT_BITS-1:0];
        end
      end
    end
  end

  assign sb_err_d = sb_err_q | dup_err | cnt_err;

  // NOTE: the regfile is reset because the architecture requires every
  // register to read 0 after reset. This is not just for simulation cleanliness.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so all registers update together.
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
        cnt_q[r]  <= cnt_d[r];
      end
      sb_err_q <= sb_err_d;
    end
  end

  // Read ports.
  always_comb begin
    rd_data_o   = '0;
    rd_hazard_o = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_sel_w[i] = rd_sel_i[i*RSEL +: RSEL];
      rd_data_o[i*XLEN +: XLEN] = regs_q[rd_sel_w[i]];
      rd_hazard_o[i] = rd_use_i[i] && rd_sel_w[i] != '0 && cnt_q[rd_sel_w[i]] != '0;
`ifdef MR_RF_WB_BYPASS_EN
      for (int p = 0; p < NWB; p++) begin
        if (wb_valid_i[p] && wb_reg_i[p*RSEL +: RSEL] == rd_sel_w[i])
          rd_data_o[i*XLEN +: XLEN] = wb_val_i[p*XLEN +: XLEN];
      end
      // The last outstanding writer retires now, and no new writer is claimed.
      if (cnt_q[rd_sel_w[i]] == CNT_BITS'(1) && ret_cnt[rd_sel_w[i]] != '0 &&
          !(claim_acc && claim_reg_i == rd_sel_w[i]))
        rd_hazard_o[i] = 1'b0;
`endif
      if (rd_sel_w[i] == '0) rd_data_o[i*XLEN +: XLEN] = '0;
    end
  end

  always_comb begin
    pending_any_o = 1'b0;
    for (int r = 0; r < NREGS; r++) pending_any_o = pending_any_o | (cnt_q[r] != '0);
  end

  assign sb_err_o = sb_err_q;

`ifndef SYNTHESIS
  if (CHECK_SB_ERR) begin : g_err_chk
    a_no_sb_err: assert property (@(posedge clk) disable iff (rst) !$rose(sb_err_o));
  end
`endif

endmodule

// File: tb/tb_mr_rf_scoreboard.sv
module tb_mr_rf_scoreboard;

  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWB = 2, CNT_BITS = 2;
  localparam int RSEL = 5;
  localparam int MAXC = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NRD*RSEL-1:0]   rd_sel;
  logic [NRD-1:0]        rd_use;
  logic [NRD*XLEN-1:0]   rd_data;
  logic [NRD-1:0]        rd_hazard;
  logic                  claim_valid;
  logic [RSEL-1:0]       claim_reg;
  logic                  claim_ready;
  logic [NWB-1:0]        wb_valid;
  logic [NWB*RSEL-1:0]   wb_reg;
  logic [NWB*XLEN-1:0]   wb_val;
  logic                  flush;
  logic                  pending_any;
  logic                  sb_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain register values and integer pending counts.
  logic [XLEN-1:0] m_reg [NREGS];
  int              m_cnt [NREGS];
  bit              m_err;

  mr_rf_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWB(NWB), .CNT_BITS(CNT_BITS),
    .CHECK_SB_ERR(1'b0)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_sel_i(rd_sel), .rd_use_i(rd_use), .rd_data_o(rd_data), .rd_hazard_o(rd_hazard),
    .claim_valid_i(claim_valid), .claim_reg_i(claim_reg), .claim_ready_o(claim_ready),
    .wb_valid_i(wb_valid), .wb_reg_i(wb_reg), .wb_val_i(wb_val),
    .flush_i(flush), .pending_any_o(pending_any), .sb_err_o(sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic bit bypass_en();
`ifdef MR_RF_WB_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int hits(int r);
    int n = 0;
    if (r == 0) return 0;
    for (int p = 0; p < NWB; p++)
      if (wb_valid[p] && int'(wb_reg[p*RSEL +: RSEL]) == r) n++;
    return n;
  endfunction

  function automatic bit exp_ready();
    int cr = int'(claim_reg);
    if (rst) return 1'b0;
    if (cr == 0 || m_cnt[cr] != MAXC) return 1'b1;
    return bypass_en() && hits(cr) > 0;
  endfunction

  function automatic bit exp_acc();
    return claim_valid && exp_ready() && !flush;
  endfunction

  function automatic logic [XLEN-1:0] exp_data(int sel);
    logic [XLEN-1:0] d;
    if (sel == 0) return '0;
    d = m_reg[sel];
    if (bypass_en())
      for (int p = 0; p < NWB; p++)
        if (wb_valid[p] && int'(wb_reg[p*RSEL +: RSEL]) == sel) d = wb_val[p*XLEN +: XLEN];
    return d;
  endfunction

  function automatic bit exp_haz(int i);
    int sel = int'(rd_sel[i*RSEL +: RSEL]);
    if (!rd_use[i] || sel == 0 || m_cnt[sel] == 0) return 1'b0;
    if (bypass_en() && m_cnt[sel] == 1 && hits(sel) > 0 &&
        !(exp_acc() && int'(claim_reg) == sel))
      return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_pending();
    for (int r = 0; r < NREGS; r++) if (m_cnt[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_update();
    int  h [NREGS];
    bit  acc;
    int  n;
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin m_reg[r] = '0; m_cnt[r] = 0; end
      m_err = 1'b0;
      return;
    end
    acc = exp_acc();
    for (int r = 0; r < NREGS; r++) h[r] = hits(r);
    for (int p = 0; p < NWB; p++)
      if (wb_valid[p] && wb_reg[p*RSEL +: RSEL] != 0)
        m_reg[wb_reg[p*RSEL +: RSEL]] = wb_val[p*XLEN +: XLEN];
    for (int r = 0; r < NREGS; r++) if (h[r] > 1) m_err = 1'b1;
    for (int r = 1; r < NREGS; r++) begin
      if (flush) m_cnt[r] = 0;
      else begin
        n = m_cnt[r] + ((acc && int'(claim_reg) == r) ? 1 : 0) - h[r];
        if (n < 0) begin n = 0; m_err = 1'b1; end
        else if (n > MAXC) begin n = MAXC; m_err = 1'b1; end
        m_cnt[r] = n;
      end
    end
  endtask

  // Move to the negedge and compare every output with the model.
  task automatic settle();
    @(negedge clk);
    for (int i = 0; i < NRD; i++) begin
      check($sformatf("rd_data%0d", i), rd_data[i*XLEN +: XLEN],
            exp_data(int'(rd_sel[i*RSEL +: RSEL])));
      check($sformatf("rd_hazard%0d", i), rd_hazard[i], exp_haz(i));
    end
    check("claim_ready", claim_ready, exp_ready());
    check("pending_any", pending_any, exp_pending());
    check("sb_err", sb_err, m_err);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic idle();
    rst = 0; rd_sel = '0; rd_use = '0; claim_valid = 0; claim_reg = '0;
    wb_valid = '0; wb_reg = '0; wb_val = '0; flush = 0;
  endtask

  task automatic set_wb(int p, int r, logic [XLEN-1:0] v);
    wb_valid[p] = 1'b1;
    wb_reg[p*RSEL +: RSEL] = RSEL'(r);
    wb_val[p*XLEN +: XLEN] = v;
  endtask

  task automatic claim(int r);
    idle(); claim_valid = 1; claim_reg = RSEL'(r); cyc();
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) begin m_reg[r] = '0; m_cnt[r] = 0; end
    m_err = 0;
    idle();
    rst = 1;
    tick();  // DUT state is unknown before the first reset edge
    tick();

    // Reset state: read x5 and x0.
    idle();
    rd_sel = {5'd0, 5'd5}; rd_use = 2'b11; claim_reg = 5'd5;
    settle();
    check("rst_data_x5", rd_data[31:0], 32'h0);
    check("rst_data_x0", rd_data[63:32], 32'h0);
    check("rst_hazard", rd_hazard, 2'b00);
    check("rst_pending", pending_any, 1'b0);
    check("rst_ready", claim_ready, 1'b1);
    tick();

    // Claim x5, observe hazard, retire it, observe data.
    claim(5);
    idle(); rd_sel[4:0] = 5'd5; rd_use = 2'b01;
    settle(); check("x5_hazard_set", rd_hazard[0], 1'b1); tick();
    idle(); rd_sel[4:0] = 5'd5; rd_use = 2'b01; set_wb(0, 5, 32'hDEADBEEF); cyc();
    idle(); rd_sel[4:0] = 5'd5; rd_use = 2'b01;
    settle();
    check("x5_hazard_clr", rd_hazard[0], 1'b0);
    check("x5_data", rd_data[31:0], 32'hDEADBEEF);
    tick();

    // Counter saturation back-pressure on x7.
    claim(7); claim(7); claim(7);
    idle(); claim_reg = 5'd7;
    settle(); check("x7_sat_ready", claim_ready, 1'b0);
    claim_reg = 5'd8; #1; check("x8_ready", claim_ready, 1'b1);
    tick();
    idle(); claim_reg = 5'd7; set_wb(0, 7, 32'h77); cyc();
    idle(); claim_reg = 5'd7;
    settle(); check("x7_ready_back", claim_ready, 1'b1); tick();

    // Claim and retire to x3 in the same cycle net out.
    claim(3);
    idle(); claim_valid = 1; claim_reg = 5'd3; set_wb(0, 3, 32'h33);
    rd_sel[4:0] = 5'd3; rd_use = 2'b01; cyc();
    idle(); rd_sel[4:0] = 5'd3; rd_use = 2'b01;
    settle();
    check("x3_hazard_kept", rd_hazard[0], 1'b1);
    check("x3_data", rd_data[31:0], 32'h33);
    tick();

    // Both WB ports hit x9: highest port wins, duplicate flags error.
    claim(9); claim(9);
    idle(); set_wb(0, 9, 32'h1); set_wb(1, 9, 32'h2); cyc();
    idle(); rd_sel[4:0] = 5'd9; rd_use = 2'b01;
    settle();
    check("x9_hazard", rd_hazard[0], 1'b0);
    check("x9_data", rd_data[31:0], 32'h2);
    check("dup_err", sb_err, 1'b1);
    tick();
    idle(); set_wb(0, 4, 32'h44); cyc();
    idle(); rd_sel[4:0] = 5'd4; rd_use = 2'b01;
    settle();
    check("err_sticky", sb_err, 1'b1);
    check("x4_no_hazard", rd_hazard[0], 1'b0);
    tick();

    // Flush drops counts and the same-cycle claim; WB data still lands.
    claim(1); claim(2);
    idle(); flush = 1; claim_valid = 1; claim_reg = 5'd6; set_wb(0, 1, 32'h55); cyc();
    idle(); rd_sel = {5'd6, 5'd1}; rd_use = 2'b11;
    settle();
    check("flush_pending", pending_any, 1'b0);
    check("flush_x1_data", rd_data[31:0], 32'h55);
    check("flush_x6_hazard", rd_hazard[1], 1'b0);
    tick();

`ifdef MR_RF_WB_BYPASS_EN
    claim(5);
    idle(); rd_sel[4:0] = 5'd5; rd_use = 2'b01; set_wb(0, 5, 32'h12);
    settle();
    check("byp_data", rd_data[31:0], 32'h12);
    check("byp_hazard", rd_hazard[0], 1'b0);
    tick();
`endif

    // Randomized traffic against the model.
    idle(); rst = 1; tick();
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst         = ($urandom_range(0, 63) == 0);
      flush       = ($urandom_range(0, 15) == 0);
      claim_valid = ($urandom_range(0, 9) < 6);
      claim_reg   = RSEL'($urandom_range(0, 7));
      for (int i = 0; i < NRD; i++) begin
        rd_sel[i*RSEL +: RSEL] = RSEL'($urandom_range(0, 8));
        rd_use[i] = ($urandom_range(0, 3) != 0);
      end
      for (int p = 0; p < NWB; p++)
        if ($urandom_range(0, 3) == 0) set_wb(p, $urandom_range(0, 7), $urandom());
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
